// File: rtl/ttt_pkg.sv
// Shared codes and state encoding for the tic-tac-toe move sequencer.
package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam logic [3:0] MAX_POS = 4'(NUM_CELLS);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;

    localparam logic [1:0] RSP_OK    = 2'b00;
    localparam logic [1:0] RSP_OCC   = 2'b01;
    localparam logic [1:0] RSP_RANGE = 2'b10;
    localparam logic [1:0] RSP_TMO   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        OVER
    } state_t;

    function automatic logic pos_in_range(input logic [3:0] pos);
        return (pos >= 4'd1) && (pos <= MAX_POS);
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Move request, core feedback and response signals of the move sequencer.
interface move_sequencer_if;
    logic        mv_valid;
    logic        mv_ready;
    logic [3:0]  mv_pos;
    logic        new_game;
    logic [17:0] board;
    logic [1:0]  win;
    logic        play;
    logic [3:0]  pos_playX;
    logic [3:0]  pos_play0;
    logic        turn;
    logic [3:0]  move_cnt;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic        game_over;
    logic        draw;

    modport slave (
        input  mv_valid, mv_pos, new_game, board, win,
        output mv_ready, play, pos_playX, pos_play0, turn, move_cnt,
               rsp_valid, rsp_code, game_over, draw
    );

    modport master (
        output mv_valid, mv_pos, new_game, board, win,
        input  mv_ready, play, pos_playX, pos_play0, turn, move_cnt,
               rsp_valid, rsp_code, game_over, draw
    );
endinterface

// File: rtl/cell_select.sv
// Picks one 2-bit cell out of the packed board; positions outside 1..9 read as empty.
module cell_select
    import ttt_pkg::*;
(
    input  logic [2*NUM_CELLS-1:0] i_board,
    input  logic [3:0]             i_pos,
    output logic [1:0]             o_cell
);

    logic [1:0] w_cells [NUM_CELLS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            assign w_cells[gi] = i_board[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        o_cell = CELL_EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (i_pos == 4'(i + 1)) begin
                o_cell = w_cells[i];
            end
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Tic-tac-toe move front end: checks, strobes and confirms moves, alternating X/O.
// Define SWAP_START_EN to alternate the starting player on every new_game.
module move_sequencer
    import ttt_pkg::*;
#(
    parameter int ACK_TIMEOUT = 8
)
(
    input  logic            clk,
    input  logic            rst,
    move_sequencer_if.slave bus
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    state_t      r_state, w_state_next;
    logic [3:0]  r_pos_q, w_pos_q_next;
    logic [TW-1:0] r_tmo, w_tmo_next;
    logic        r_mv_ready, w_mv_ready_next;
    logic        r_play, w_play_next;
    logic [3:0]  r_pos_x, w_pos_x_next;
    logic [3:0]  r_pos_o, w_pos_o_next;
    logic        r_turn, w_turn_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_rsp_valid, w_rsp_valid_next;
    logic [1:0]  r_rsp_code, w_rsp_code_next;
    logic        r_game_over, w_game_over_next;
    logic        r_draw, w_draw_next;
`ifdef SWAP_START_EN
    logic        r_start, w_start_next;
`endif

    logic [1:0]  w_cell;
    logic [1:0]  w_own;
    logic [1:0]  w_other;
    logic        w_win_set;

    cell_select u_cell_select (
        .i_board (bus.board),
        .i_pos   (r_pos_q),
        .o_cell  (w_cell)
    );

    assign w_own     = r_turn ? CELL_O : CELL_X;
    assign w_other   = r_turn ? CELL_X : CELL_O;
    // Code 11 on win is not a real winner and is handled like no win.
    assign w_win_set = (bus.win == WIN_X) || (bus.win == WIN_O);

    always_comb begin
        w_state_next     = r_state;
        w_pos_q_next     = r_pos_q;
        w_tmo_next       = r_tmo;
        w_play_next      = 1'b0;
        w_pos_x_next     = 4'd0;
        w_pos_o_next     = 4'd0;
        w_turn_next      = r_turn;
        w_cnt_next       = r_cnt;
        w_rsp_valid_next = 1'b0;
        w_rsp_code_next  = r_rsp_code;
`ifdef SWAP_START_EN
        w_start_next     = r_start;
`endif

        case (r_state)
            IDLE: begin
                if (w_win_set) begin
                    w_state_next = OVER;
                end else if (bus.mv_valid && r_mv_ready) begin
                    w_pos_q_next = bus.mv_pos;
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (!pos_in_range(r_pos_q)) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_code_next  = RSP_RANGE;
                    w_state_next     = IDLE;
                end else if (w_cell != CELL_EMPTY) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_code_next  = RSP_OCC;
                    w_state_next     = IDLE;
                end else begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_play_next = 1'b1;
                if (r_turn) begin
                    w_pos_o_next = r_pos_q;
                end else begin
                    w_pos_x_next = r_pos_q;
                end
                w_tmo_next   = '0;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (w_cell == w_own) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_code_next  = RSP_OK;
                    w_cnt_next       = (r_cnt >= MAX_POS) ? MAX_POS : r_cnt + 4'd1;
                    w_turn_next      = ~r_turn;
                    w_state_next     = (w_win_set || (w_cnt_next == MAX_POS)) ? OVER : IDLE;
                end else if ((w_cell == w_other) || (r_tmo == TMO_LAST)) begin
                    w_rsp_valid_next = 1'b1;
                    w_rsp_code_next  = RSP_TMO;
                    w_state_next     = IDLE;
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end
            OVER: begin
                w_state_next = OVER;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A restart overrides whatever the current state decided above.
        if (bus.new_game) begin
            w_state_next     = IDLE;
            w_cnt_next       = 4'd0;
            w_tmo_next       = '0;
            w_play_next      = 1'b0;
            w_pos_x_next     = 4'd0;
            w_pos_o_next     = 4'd0;
            w_rsp_valid_next = 1'b0;
`ifdef SWAP_START_EN
            w_start_next     = ~r_start;
            w_turn_next      = ~r_start;
`else
            w_turn_next      = 1'b0;
`endif
        end

        w_mv_ready_next  = (w_state_next == IDLE);
        w_game_over_next = (w_state_next == OVER);
        w_draw_next      = (w_state_next == OVER) && !w_win_set && (w_cnt_next == MAX_POS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_pos_q     <= 4'd0;
            r_tmo       <= '0;
            r_mv_ready  <= 1'b1;
            r_play      <= 1'b0;
            r_pos_x     <= 4'd0;
            r_pos_o     <= 4'd0;
            r_turn      <= 1'b0;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= RSP_OK;
            r_game_over <= 1'b0;
            r_draw      <= 1'b0;
`ifdef SWAP_START_EN
            r_start     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_pos_q     <= w_pos_q_next;
            r_tmo       <= w_tmo_next;
            r_mv_ready  <= w_mv_ready_next;
            r_play      <= w_play_next;
            r_pos_x     <= w_pos_x_next;
            r_pos_o     <= w_pos_o_next;
            r_turn      <= w_turn_next;
            r_cnt       <= w_cnt_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_code  <= w_rsp_code_next;
            r_game_over <= w_game_over_next;
            r_draw      <= w_draw_next;
`ifdef SWAP_START_EN
            r_start     <= w_start_next;
`endif
        end
    end

    assign bus.mv_ready  = r_mv_ready;
    assign bus.play      = r_play;
    assign bus.pos_playX = r_pos_x;
    assign bus.pos_play0 = r_pos_o;
    assign bus.turn      = r_turn;
    assign bus.move_cnt  = r_cnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_code  = r_rsp_code;
    assign bus.game_over = r_game_over;
    assign bus.draw      = r_draw;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: stimulus queues expected strobes, a monitor checks them.
module tb_move_sequencer;
    import ttt_pkg::*;

    localparam int ACK = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    move_sequencer_if bus ();

    move_sequencer #(.ACK_TIMEOUT(ACK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] code;
        logic       turn;
        logic [3:0] cnt;
        int         when;
    } rsp_t;

    typedef struct {
        logic [3:0] px;
        logic [3:0] po;
        int         when;
    } play_t;

    rsp_t  rsp_q [$];
    play_t play_q [$];
    rsp_t  mr;
    play_t mp;

    int   cyc      = 0;
    int   errors   = 0;
    int   checks   = 0;
    int   rsp_seen = 0;
    bit   mon_en   = 1'b0;
    logic t0       = 1'b0;
    logic cur_turn = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.rsp_valid) begin
            rsp_seen++;
            if (rsp_q.size() == 0) begin
                fail("unexpected_rsp");
            end else begin
                mr = rsp_q.pop_front();
                $display("rsp  cyc=%0d code=%0d turn=%0d cnt=%0d", cyc, bus.rsp_code, bus.turn, bus.move_cnt);
                chk("rsp_code", int'(bus.rsp_code), int'(mr.code));
                chk("rsp_turn", int'(bus.turn), int'(mr.turn));
                chk("rsp_cnt", int'(bus.move_cnt), int'(mr.cnt));
                chk("rsp_cycle", cyc, mr.when);
            end
        end
        if (mon_en && bus.play) begin
            if (play_q.size() == 0) begin
                fail("unexpected_play");
            end else begin
                mp = play_q.pop_front();
                $display("play cyc=%0d X=%0d O=%0d", cyc, bus.pos_playX, bus.pos_play0);
                chk("play_x", int'(bus.pos_playX), int'(mp.px));
                chk("play_o", int'(bus.pos_play0), int'(mp.po));
                chk("play_cycle", cyc, mp.when);
            end
        end
    end

    task automatic check_reset(input string tag);
        $display("%s: checking reset values", tag);
        chk({tag, "_ready"}, int'(bus.mv_ready), 1);
        chk({tag, "_play"}, int'(bus.play), 0);
        chk({tag, "_px"}, int'(bus.pos_playX), 0);
        chk({tag, "_po"}, int'(bus.pos_play0), 0);
        chk({tag, "_turn"}, int'(bus.turn), 0);
        chk({tag, "_cnt"}, int'(bus.move_cnt), 0);
        chk({tag, "_rspv"}, int'(bus.rsp_valid), 0);
        chk({tag, "_rspc"}, int'(bus.rsp_code), 0);
        chk({tag, "_over"}, int'(bus.game_over), 0);
        chk({tag, "_draw"}, int'(bus.draw), 0);
    endtask

    // Issues one request; commit/w describe how the core model reacts to the strobe.
    task automatic move(input logic [3:0] p, input bit commit, input logic [1:0] w,
                        input logic [1:0] code, input logic t_after, input logic [3:0] c_after);
        int n = 0;
        int acc;
        int lat;
        @(negedge clk);
        while (!bus.mv_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mv_ready) begin
            fail("ready_timeout");
            return;
        end
        $display("move pos=%0d expect code=%0d turn=%0d cnt=%0d", p, code, t_after, c_after);
        bus.mv_valid = 1'b1;
        bus.mv_pos   = p;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.mv_valid = 1'b0;
        bus.mv_pos   = 4'd0;
        lat = (code == RSP_OK) ? 3 : ((code == RSP_TMO) ? ACK + 2 : 1);
        rsp_q.push_back('{code, t_after, c_after, acc + lat});
        if (code == RSP_OK || code == RSP_TMO) begin
            play_q.push_back('{(cur_turn ? 4'd0 : p), (cur_turn ? p : 4'd0), acc + 2});
            @(posedge clk);
            @(posedge clk);
            #1;
            if (bus.play && commit) begin
                bus.board[2*(int'(p)-1) +: 2] = cur_turn ? CELL_O : CELL_X;
                bus.win = w;
            end
        end
        n = 0;
        while (rsp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0) begin
            fail("rsp_timeout");
            rsp_q.delete();
        end
        cur_turn = t_after;
    endtask

    task automatic start_game();
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        bus.board    = '0;
        bus.win      = WIN_NONE;
`ifdef SWAP_START_EN
        t0 = ~t0;
`endif
        cur_turn = t0;
        $display("new_game start=%0d", t0);
        chk("ng_cnt", int'(bus.move_cnt), 0);
        chk("ng_turn", int'(bus.turn), int'(t0));
        chk("ng_over", int'(bus.game_over), 0);
        chk("ng_draw", int'(bus.draw), 0);
        chk("ng_ready", int'(bus.mv_ready), 1);
        chk("ng_rspv", int'(bus.rsp_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n_rsp;
        logic [3:0] kk;
        bus.mv_valid = 1'b0;
        bus.mv_pos   = 4'd0;
        bus.new_game = 1'b0;
        bus.board    = '0;
        bus.win      = WIN_NONE;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_release");
        mon_en = 1'b1;

        // first move, then occupied and out-of-range rejections
        move(4'd5, 1'b1, WIN_NONE, RSP_OK, 1'b1, 4'd1);
        move(4'd5, 1'b1, WIN_NONE, RSP_OCC, 1'b1, 4'd1);
        move(4'd0, 1'b1, WIN_NONE, RSP_RANGE, 1'b1, 4'd1);
        move(4'd12, 1'b1, WIN_NONE, RSP_RANGE, 1'b1, 4'd1);

        // core never commits: timeout after ACK cycles in WAIT
        move(4'd3, 1'b0, WIN_NONE, RSP_TMO, 1'b1, 4'd1);
        chk("tmo_ready", int'(bus.mv_ready), 1);

        // winning game: start player takes 1,2,3; the other takes 4,5
        start_game();
        move(4'd1, 1'b1, WIN_NONE, RSP_OK, t0 ^ 1'b1, 4'd1);
        move(4'd4, 1'b1, WIN_NONE, RSP_OK, t0, 4'd2);
        move(4'd2, 1'b1, WIN_NONE, RSP_OK, t0 ^ 1'b1, 4'd3);
        move(4'd5, 1'b1, WIN_NONE, RSP_OK, t0, 4'd4);
        move(4'd3, 1'b1, (t0 ? WIN_O : WIN_X), RSP_OK, t0 ^ 1'b1, 4'd5);
        chk("win_over", int'(bus.game_over), 1);
        chk("win_draw", int'(bus.draw), 0);
        chk("win_ready", int'(bus.mv_ready), 0);
        n_rsp = rsp_seen;
        bus.mv_valid = 1'b1;
        bus.mv_pos   = 4'd9;
        repeat (6) @(negedge clk);
        bus.mv_valid = 1'b0;
        bus.mv_pos   = 4'd0;
        $display("held request pos=9 during OVER");
        chk("over_no_rsp", rsp_seen, n_rsp);
        chk("over_cnt", int'(bus.move_cnt), 5);
        chk("over_still", int'(bus.game_over), 1);

        // draw game: nine legal moves, no win
        start_game();
        for (int k = 1; k <= 9; k++) begin
            kk = 4'(k);
            move(kk, 1'b1, WIN_NONE, RSP_OK, t0 ^ kk[0], kk);
        end
        chk("draw_flag", int'(bus.draw), 1);
        chk("draw_over", int'(bus.game_over), 1);
        chk("draw_cnt", int'(bus.move_cnt), 9);
        chk("draw_ready", int'(bus.mv_ready), 0);
        start_game();

        // new_game while waiting for the core
        @(negedge clk);
        bus.mv_valid = 1'b1;
        bus.mv_pos   = 4'd7;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.mv_valid = 1'b0;
        bus.mv_pos   = 4'd0;
        play_q.push_back('{(t0 ? 4'd0 : 4'd7), (t0 ? 4'd7 : 4'd0), acc + 2});
        n_rsp = rsp_seen;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.new_game = 1'b1;
        @(posedge clk);
        #1;
        bus.new_game = 1'b0;
`ifdef SWAP_START_EN
        t0 = ~t0;
`endif
        cur_turn = t0;
        @(negedge clk);
        $display("new_game during WAIT");
        chk("ngw_ready", int'(bus.mv_ready), 1);
        chk("ngw_rspv", int'(bus.rsp_valid), 0);
        chk("ngw_cnt", int'(bus.move_cnt), 0);
        chk("ngw_turn", int'(bus.turn), int'(t0));
        repeat (12) @(negedge clk);
        chk("ngw_no_rsp", rsp_seen, n_rsp);

        // reset dropped while the strobe is being prepared
        move(4'd2, 1'b1, WIN_NONE, RSP_OK, t0 ^ 1'b1, 4'd1);
        @(negedge clk);
        bus.mv_valid = 1'b1;
        bus.mv_pos   = 4'd6;
        @(posedge clk);
        #1;
        bus.mv_valid = 1'b0;
        bus.mv_pos   = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("rst_issue");
        rst = 1'b1;
        bus.board = '0;
        repeat (4) @(negedge clk);

        chk("play_q_empty", play_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Upstream front end of the tic-tac-toe core.
- Accepts single-player-agnostic move requests (position 1..9) over a valid/ready handshake and alternates turns X/O.
- Pre-checks range and occupancy against the fed-back board, then issues a one-cycle play strobe with the position on the correct player port.
- Waits for the core to commit the cell, tracks move count and game end, and reports a per-move response code.

Parameters:
- ACK_TIMEOUT, 8, max cycles in WAIT for the board cell to become non-empty before a timeout response.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- mv_valid  in  1  move request valid
- mv_ready  out  1  sequencer can accept a move
- mv_pos  in  4  requested position, legal 1..9
- new_game  in  1  one-cycle pulse: restart sequencing (board clearing is the core's rst, driven externally)
- board  in  18  pos1 in [1:0] .. pos9 in [17:16]; cell code 00 empty, 01 X, 10 O
- win  in  2  00 none, 01 X wins, 10 O wins, 11 treated as none
- play  out  1  one-cycle move strobe to the core
- pos_playX  out  4  X position; 0 when not X's strobe
- pos_play0  out  4  O position; 0 when not O's strobe
- turn  out  1  0 = X to move, 1 = O to move
- move_cnt  out  4  committed moves this game, 0..9
- rsp_valid  out  1  one-cycle response strobe
- rsp_code  out  2  00 ok, 01 occupied, 10 out of range, 11 timeout
- game_over  out  1  high in OVER
- draw  out  1  game ended with move_cnt==9 and win==00

Behaviour:
- One clock, clk. Reset rst is synchronous and active-low.
- Reset values: state IDLE, mv_ready 1, play 0, pos_playX/pos_play0 0, turn 0, move_cnt 0, rsp_valid 0, rsp_code 00, game_over 0, draw 0, timeout counter 0.
- States: IDLE, CHECK, ISSUE, WAIT, OVER. All outputs are registered.
- IDLE:
  - mv_ready=1.
  - On mv_valid&mv_ready, latch mv_pos into pos_q and go to CHECK.
  - If win!=00 (01/10) in IDLE, go to OVER without consuming a move.
- CHECK (1 cycle):
  - pos_q==0 or pos_q>9: rsp_code 10, back to IDLE.
  - Else if board cell pos_q != 00: rsp_code 01, back to IDLE.
  - Else go to ISSUE.
  - In both reject cases rsp_valid pulses one cycle, and turn and move_cnt are unchanged.
- ISSUE (1 cycle):
  - play=1.
  - pos_playX=pos_q if turn==0, else pos_play0=pos_q. The other port is 0.
  - Go to WAIT, timeout counter cleared.
- WAIT:
  - Each cycle, check board cell pos_q.
  - Cell == current player's code: rsp ok, move_cnt+1, turn toggles. Go to OVER if win is 01/10 or the new move_cnt==9, else IDLE.
  - Cell is the other code, or the counter reaches ACK_TIMEOUT-1: rsp 11, turn and move_cnt unchanged, back to IDLE.
- Request-to-strobe latency: play asserts 2 cycles after the accepting edge.
- OVER:
  - mv_ready=0, game_over=1.
  - draw=1 iff win==00 and move_cnt==9.
  - Stays until new_game.
- new_game:
  - In any state, takes priority over all transitions except rst.
  - Next cycle: state IDLE, move_cnt 0, turn = start player, game_over/draw 0, play 0, no rsp.
- win/move_cnt boundary: if win appears on the same cycle move_cnt reaches 9, OVER is entered with draw=0.
- Game-over rejection: mv_valid held while in OVER is never accepted.
- Counter widths: move_cnt saturates at 9. The timeout counter is $clog2(ACK_TIMEOUT) bits, minimum 1.

Optional Feature:
- Macro: SWAP_START_EN.
- Defined: a start-player register (reset 0) toggles on every new_game, and turn loads the new value, so starts alternate X, O, X...
- Undefined: turn always reloads 0 (X starts); no start register.
- rst always restores X.

Decomposition:
- ttt_pkg holds:
  - cell codes CELL_EMPTY/CELL_X/CELL_O
  - win codes WIN_NONE/WIN_X/WIN_O
  - rsp codes RSP_OK/RSP_OCC/RSP_RANGE/RSP_TMO
  - state enum
  - constant NUM_CELLS=9
- One natural sub-module: cell_select, a combinational mux of board by a 4-bit position returning the 2-bit cell, with 00 for out-of-range.

Test Plan:
- Reset, then move 5: play pulses at cycle+2 with pos_playX=5, pos_play0=0; model sets cell5=01 → rsp 00, turn 1, move_cnt 1.
- Next move 5 with cell5=01: rsp 01, no play, turn stays 1. Then move 0, and separately move 12: rsp 10 each, no play.
- Model never updates the board after move 3: rsp 11 exactly ACK_TIMEOUT cycles into WAIT (8), turn and move_cnt unchanged, mv_ready back to 1.
- X plays 1, 2, 3 with O on 4, 5, and the model raises win=01: game_over 1, draw 0, mv_ready 0; mv_valid with position 9 is ignored.
- Nine alternating legal moves, win stays 00: draw 1, move_cnt 9. Then new_game gives move_cnt 0, game_over 0, turn 0 (or 1 with SWAP_START_EN).
- new_game while in WAIT: next cycle IDLE, no rsp_valid. Drop rst mid-ISSUE: all outputs at reset values next cycle.
